// File: rtl/mux_2x1_arbiter.sv
// Round-robin merge of two req/ack sources into one registered valid/ready output.
// Sel tags the winning source (0 = In1, 1 = In2) so a downstream 1x2 demux can route it back.
module mux_2x1_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req1,
    input  logic [WIDTH-1:0] In1,
    output logic             Ack1,
    input  logic             Req2,
    input  logic [WIDTH-1:0] In2,
    output logic             Ack2,
    output logic             Valid,
    output logic [WIDTH-1:0] Out,
    output logic             Sel,
    input  logic             Ready
);

    // state   | meaning
    // S_EMPTY | output register holds no unconsumed word
    // S_FULL  | Out/Sel hold a word waiting for Ready
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   last;
    logic   load;
    logic   grant1;
    logic   grant2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // last = index of the source served most recently; a tie goes to the other one
    always_comb begin
        state_nxt = state;
        load      = (state == S_EMPTY) | Ready;
        grant1    = Req1 & (~Req2 | last);
        grant2    = Req2 & (~Req1 | ~last);
        Ack1      = 1'b0;
        Ack2      = 1'b0;
        if (!Reset) begin
            Ack1 = load & grant1;
            Ack2 = load & grant2;
        end
        case (state)
            S_EMPTY: if (Ack1 | Ack2) state_nxt = S_FULL;
            S_FULL:  if (Ready & ~(Ack1 | Ack2)) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    assign Valid = (state == S_FULL);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out  <= '0;
            Sel  <= 1'b0;
            last <= 1'b1;
        end else if (Ack1) begin
            Out  <= In1;
            Sel  <= 1'b0;
            last <= 1'b0;
        end else if (Ack2) begin
            Out  <= In2;
            Sel  <= 1'b1;
            last <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter: reset, fairness, backpressure, streaming, async reset.
module tb_mux_2x1_arbiter;

    logic       Clk;
    logic       Reset;
    logic       Req1, Req2;
    logic [7:0] In1, In2;
    logic       Ack1, Ack2;
    logic       Valid;
    logic [7:0] Out;
    logic       Sel;
    logic       Ready;

    int n_cmp = 0;
    int n_bad = 0;

    mux_2x1_arbiter #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Req1  (Req1),
        .In1   (In1),
        .Ack1  (Ack1),
        .Req2  (Req2),
        .In2   (In2),
        .Ack2  (Ack2),
        .Valid (Valid),
        .Out   (Out),
        .Sel   (Sel),
        .Ready (Ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_ack(input string tag, input logic a1, input logic a2);
        chk({tag, ".ack1"}, 32'(Ack1), 32'(a1));
        chk({tag, ".ack2"}, 32'(Ack2), 32'(a2));
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        chk({tag, ".valid"}, 32'(Valid), 32'(v));
        chk({tag, ".out"},   32'(Out),   32'(d));
        chk({tag, ".sel"},   32'(Sel),   32'(s));
    endtask

    // Sources must hold Req until acknowledged
    logic pend1 = 1'b0;
    logic pend2 = 1'b0;
    always @(posedge Clk) begin
        if (!Reset) begin
            if (pend1 && !Req1) $error("protocol: Req1 dropped without Ack1");
            if (pend2 && !Req2) $error("protocol: Req2 dropped without Ack2");
        end
        pend1 = Req1 && !Ack1 && !Reset;
        pend2 = Req2 && !Ack2 && !Reset;
    end

    initial begin
        Reset = 1'b1;
        Req1  = 1'b1;
        Req2  = 1'b1;
        In1   = 8'h11;
        In2   = 8'h22;
        Ready = 1'b1;

        // reset holds everything idle even with requests pending
        tick();
        tick();
        chk_ack("rst", 1'b0, 1'b0);
        chk_out("rst", 1'b0, 8'h00, 1'b0);
        Reset = 1'b0;
        #1;
        chk_ack("rst_rel", 1'b1, 1'b0);

        // fairness: alternate 11,22,...
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out($sformatf("fair%0d", i), 1'b1, (i % 2 == 0) ? 8'h11 : 8'h22, 1'(i % 2));
        end
        tick();
        chk_out("fair6", 1'b1, 8'h11, 1'b0);

        // backpressure
        Ready = 1'b0;
        #1;
        chk_ack("bp", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ack($sformatf("bp%0d", i), 1'b0, 1'b0);
            chk_out($sformatf("bp%0d", i), 1'b1, 8'h11, 1'b0);
        end
        Ready = 1'b1;
        #1;
        chk_ack("bp_rel", 1'b0, 1'b1);
        tick();
        chk_out("bp_rel", 1'b1, 8'h22, 1'b1);
        Req2 = 1'b0;
        #1;
        chk_ack("drain", 1'b1, 1'b0);
        tick();
        chk_out("drain", 1'b1, 8'h11, 1'b0);
        Req1 = 1'b0;
        #1;
        chk_ack("idle", 1'b0, 1'b0);
        tick();
        chk_out("idle", 1'b0, 8'h11, 1'b0);

        // single source
        Req1 = 1'b1;
        In1  = 8'hA5;
        #1;
        chk_ack("single", 1'b1, 1'b0);
        tick();
        chk_out("single", 1'b1, 8'hA5, 1'b0);
        Req1 = 1'b0;
        tick();
        chk("single_empty", 32'(Valid), 32'd0);

        // back-to-back from source 2, no bubbles
        Req2 = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            In2 = 8'(v);
            #1;
            chk_ack($sformatf("b2b%0d", v), 1'b0, 1'b1);
            tick();
            chk_out($sformatf("b2b%0d", v), 1'b1, 8'(v), 1'b1);
        end

        // async reset mid-operation
        In2 = 8'h22;
        #1;
        tick();
        chk_out("pre_rst", 1'b1, 8'h22, 1'b1);
        Req2  = 1'b0;
        Ready = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 1'b0);
        chk_ack("mid_rst", 1'b0, 1'b0);
        Reset = 1'b0;
        Req1  = 1'b1;
        Req2  = 1'b1;
        In1   = 8'h11;
        Ready = 1'b1;
        #1;
        chk_ack("post_rst", 1'b1, 1'b0);
        tick();
        chk_out("post_rst", 1'b1, 8'h11, 1'b0);
        Req1 = 1'b0;
        #1;
        chk_ack("post_rst2", 1'b0, 1'b1);
        tick();
        chk_out("post_rst2", 1'b1, 8'h22, 1'b1);
        Req2 = 1'b0;
        tick();
        chk("final_empty", 32'(Valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
- Merges two independent request/acknowledge source channels into one registered output channel.
- This is the merge-side counterpart to the 1x2 demux: the demux fans one stream out by Sel, and this block fans two streams in.
- The output carries Sel to tag the source: 0 = source 1 and 1 = source 2, using the same encoding the demux uses, so a downstream demux can route the data back.
- Fair round-robin arbitration with a one-entry output register; sits between two producers and a single shared consumer.

Parameters:
WIDTH, 8, data width of In1, In2 and Out.

Ports:
Clk  input  1  clock, all state on rising edge.
Reset  input  1  asynchronous, active-high reset.
Req1  input  1  source 1 has data on In1; held until Ack1.
In1  input  WIDTH  source 1 data; stable while Req1 high.
Ack1  output  1  source 1 transfer this cycle (combinational).
Req2  input  1  source 2 has data on In2; held until Ack2.
In2  input  WIDTH  source 2 data; stable while Req2 high.
Ack2  output  1  source 2 transfer this cycle (combinational).
Valid  output  1  Out/Sel hold an unconsumed word.
Out  output  WIDTH  registered data word.
Sel  output  1  source of Out: 0 = In1, 1 = In2.
Ready  input  1  consumer accepts Out this cycle when Valid high.

Behaviour:
- Reset (async, Reset=1): Valid=0, Out=0, Sel=0, internal Last=1 (source 2 last served, so source 1 wins first tie). Ack1=Ack2=0 while Reset high.
- Load enable: Load = ~Valid | Ready.
- Grant:
  - Only Req1 high → source 1.
  - Only Req2 high → source 2.
  - Both high → source opposite to Last.
  - Neither high → no grant.
- Ack outputs: Ack1 = Load & grant1; Ack2 = Load & grant2. At most one Ack is high per cycle. Ack depends on Ready combinationally; no path from Ack back to Req is allowed.
- On rising edge when an Ack is high:
  - Out <= granted In.
  - Sel <= granted index (0/1).
  - Valid <= 1.
  - Last <= granted index.
- On rising edge with Valid & Ready and no Ack: Valid <= 0. Out and Sel hold their last values.
- Valid=1 & Ready=0: Out, Sel and Valid hold; Ack1=Ack2=0 (backpressure to both sources).
- Latency: input word appears on Out with Valid=1 one cycle after its Ack cycle.
- Throughput: one word per cycle while Ready=1 and any Req is high.
- Both Req held continuously with Ready=1: grants alternate 1,2,1,2,…. No starvation; worst-case wait is 1 transfer.
- Single requester: served every cycle with no idle bubbles. Last still updates.
- Simultaneous consume and load in the same cycle: the new word replaces the old word and Valid stays 1.
- Reset mid-transfer: the pending output word is discarded and Valid drops immediately. Sources must re-present their requests after Reset deasserts. Arbitration restarts with source 1 priority.
- Req deasserted without Ack: protocol violation; the block need not handle it (the bench asserts on it).

Test Plan:
- Reset: Reset=1 with Req1=Req2=1 and Ready=1 → Ack1=Ack2=0, Valid=0, Out=0, Sel=0. Release Reset → first Ack is Ack1.
- Single source: Req1=1, In1=8'hA5, Ready=1 → Ack1=1 at cycle 0; next cycle Valid=1, Out=A5, Sel=0. Drop Req1 → Valid=0 one cycle later.
- Fairness: Req1=Req2=1, In1=8'h11, In2=8'h22, Ready=1 for 6 cycles → Out sequence 11,22,11,22,11,22 with Sel 0,1,0,1,0,1.
- Backpressure: Out=8'h11 Valid=1, Ready=0 for 3 cycles with both Req high → Ack1=Ack2=0, Out held at 11. Ready=1 → Ack2 asserted that cycle and Out=22 on the next cycle.
- Back-to-back single source: Req2=1 with In2 stepping 01..04, one value per Ack, Ready=1 → Out 01,02,03,04 on consecutive cycles, Sel=1, no bubbles.
- Reset mid-operation: Valid=1 Out=8'h22 Sel=1, pulse Reset between clock edges → Valid=0, Out=0, Sel=0 immediately without a clock edge. Next tie is granted to source 1.
